sixteenbit_lfsr: RTL and testbench

- 16-bit maximal-length Fibonacci LFSR pseudo-random sequence generator for the codeword detector datapath.
- Shifts once per clock while `sh_en` is high and exposes the full state on `Q_out`.
- Raises a registered one-cycle `max_tick_reg` flag each time the sequence completes a full period (2^16-1 = 65535 shifts) and returns to the seed.

---
 rtl/lfsr_pkg.sv | 7 +
 rtl/lfsr_next_state.sv | 18 +
 rtl/sixteenbit_lfsr.sv | 31 +++
 tb/tb_sixteenbit_lfsr.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared width, default taps/seed and state type for the LFSR datapath
package lfsr_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_TAPS = 16'hD008;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'h0001;
  typedef logic [LFSR_W-1:0] lfsr_state_t;
endpackage

// File: rtl/lfsr_next_state.sv
// lfsr_next_state: Fibonacci step with zero-lockup recovery and wrap-to-seed flag
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter lfsr_state_t SEED = LFSR_DEFAULT_SEED
) (
  input  lfsr_state_t state,
  input  lfsr_state_t taps,
  output lfsr_state_t nxt,
  output logic        wrap
);
  logic fb;
  always_comb begin
    fb = ^(state & taps);
    nxt = (state == '0) ? SEED : {state[LFSR_W-2:0], fb};
    wrap = (state != '0) && (nxt == SEED);
  end
endmodule

// File: rtl/sixteenbit_lfsr.sv
// sixteenbit_lfsr: 16-bit maximal-length LFSR with registered one-cycle period-complete tick
module sixteenbit_lfsr
  import lfsr_pkg::*;
#(
  parameter lfsr_state_t SEED = LFSR_DEFAULT_SEED,
  parameter lfsr_state_t TAPS = LFSR_DEFAULT_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sh_en,
  output lfsr_state_t Q_out,
  output logic        max_tick_reg
);
  lfsr_state_t nxt;
  logic wrap;
  lfsr_next_state #(.SEED(SEED)) u_next (
    .state(Q_out),
    .taps (TAPS),
    .nxt  (nxt),
    .wrap (wrap)
  );
  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      Q_out <= SEED;
      max_tick_reg <= 1'b0;
    end else begin
      Q_out <= sh_en ? nxt : Q_out;
      max_tick_reg <= sh_en & wrap;
    end
endmodule

// File: tb/tb_sixteenbit_lfsr.sv
// tb_sixteenbit_lfsr: directed vectors plus a shift-counting reference model checked every cycle
module tb_sixteenbit_lfsr;
  import lfsr_pkg::*;
  localparam logic [15:0] SEED = 16'h0001;
  localparam logic [15:0] TAPS = 16'hD008;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sh_en = 1'b1;
  logic [15:0] q;
  logic tick;
  int vectors = 0;
  int errs = 0;
  bit chk_en = 1'b0;
  logic [15:0] mq;
  logic mt;
  int cnt;
  bit seen [65536];
  lfsr_state_t ns_state, ns_nxt;
  logic ns_wrap;

  sixteenbit_lfsr #(.SEED(SEED), .TAPS(TAPS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sh_en       (sh_en),
    .Q_out       (q),
    .max_tick_reg(tick)
  );

  lfsr_next_state #(.SEED(SEED)) u_ns (
    .state(ns_state),
    .taps (TAPS),
    .nxt  (ns_nxt),
    .wrap (ns_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      if (errs <= 20) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    if (s == 16'h0000) return SEED;
    return 16'((s << 1) | 16'($countones(s & TAPS) % 2));
  endfunction

  // Model: state follows the tap rule, the tick comes purely from counting shifts since SEED.
  always @(posedge clk or posedge rst_n)
    if (rst_n) begin
      mq <= SEED;
      mt <= 1'b0;
      cnt <= 0;
    end else if (sh_en) begin
      mq <= step(mq);
      cnt <= (cnt == 65534) ? 0 : cnt + 1;
      mt <= (cnt == 65534);
    end else
      mt <= 1'b0;

  always @(negedge clk)
    if (chk_en) begin
      chk("model_q", q, mq);
      chk("model_tick", {15'd0, tick}, {15'd0, mt});
    end

  initial begin
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_q", q, 16'h0001);
      chk("reset_tick", {15'd0, tick}, 16'd0);
    end
    rst_n = 1'b0;
    @(negedge clk); chk("step1", q, 16'h0002);
    @(negedge clk); chk("step2", q, 16'h0004);
    @(negedge clk); chk("step3", q, 16'h0008);
    sh_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold", q, 16'h0008);
    end
    sh_en = 1'b1;
    @(negedge clk); chk("step4", q, 16'h0011);
    @(negedge clk); chk("step5", q, 16'h0022);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("async_reset_q", q, 16'h0001);
    chk("async_reset_tick", {15'd0, tick}, 16'd0);
    @(negedge clk);
    rst_n = 1'b0;
    seen[SEED] = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clk);
      if (i < 65535) begin
        chk("period_nonzero", {15'd0, q == 16'h0000}, 16'd0);
        chk("period_unique", {15'd0, seen[q]}, 16'd0);
        chk("period_tick_low", {15'd0, tick}, 16'd0);
        seen[q] = 1'b1;
      end else begin
        chk("wrap_q", q, 16'h0001);
        chk("wrap_tick", {15'd0, tick}, 16'd1);
        sh_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("tick_falls", {15'd0, tick}, 16'd0);
    chk("hold_after_wrap", q, 16'h0001);
    sh_en = 1'b1;
    @(negedge clk); chk("restart_step1", q, 16'h0002);
    chk("restart_tick", {15'd0, tick}, 16'd0);
    ns_state = 16'h0000; #1;
    chk("lockup_next", ns_nxt, 16'h0001);
    chk("lockup_wrap", {15'd0, ns_wrap}, 16'd0);
    ns_state = 16'h8000; #1;
    chk("wrap_next", ns_nxt, 16'h0001);
    chk("wrap_flag", {15'd0, ns_wrap}, 16'd1);
    ns_state = 16'h0011; #1;
    chk("plain_next", ns_nxt, 16'h0022);
    chk("plain_wrap", {15'd0, ns_wrap}, 16'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
